// File: rtl/melody_sequencer.sv
// Programmable square-wave tone sequencer: writable note-period table, per-step
// beat durations, runtime tempo, loop mode, start/stop control and status.
module melody_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int NOTE_W  = 4,
  parameter int BEAT_W  = 4,
  parameter int HP_W    = 24,
  parameter int TEMPO_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [ADDR_W:0]    len,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               seq_we,
  input  logic [ADDR_W-1:0]  seq_addr,
  input  logic [NOTE_W-1:0]  seq_note,
  input  logic [BEAT_W-1:0]  seq_beats,
  input  logic               tbl_we,
  input  logic [NOTE_W-1:0]  tbl_idx,
  input  logic [HP_W-1:0]    tbl_hp,
  output logic               speaker_out,
  output logic               busy,
  output logic [ADDR_W-1:0]  step_idx,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t              r_state;
  logic [NOTE_W-1:0]   r_mem_note  [0:2**ADDR_W-1];
  logic [BEAT_W-1:0]   r_mem_beats [0:2**ADDR_W-1];
  logic [HP_W-1:0]     r_tbl       [0:2**NOTE_W-1];
  logic [HP_W-1:0]     r_hp, r_phase;
  logic [TEMPO_W-1:0]  r_tempo, r_tick;
  logic [BEAT_W-1:0]   r_beats, r_beat;
  logic [ADDR_W-1:0]   r_step;
  logic                r_spk, r_busy, r_done;

  logic [NOTE_W-1:0]   w_note;
  logic [BEAT_W-1:0]   w_beats_raw;
  logic [HP_W-1:0]     w_hp;
  logic                w_tick_end, w_step_end, w_last;

  assign w_note      = r_mem_note[r_step];
  assign w_beats_raw = r_mem_beats[r_step];
  assign w_hp        = (w_note == '0) ? '0 : r_tbl[w_note];
  assign w_tick_end  = (r_tick == r_tempo - 1'b1);
  assign w_step_end  = w_tick_end && (r_beat == r_beats - 1'b1);
  // len is sampled live, so a shrinking len ends the run at this step.
  assign w_last      = ((ADDR_W+1)'(r_step) + (ADDR_W+1)'(1)) >= len;

  // Sequence memory is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (seq_we) begin
      r_mem_note[seq_addr]  <= seq_note;
      r_mem_beats[seq_addr] <= seq_beats;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**NOTE_W; i++) r_tbl[i] <= '0;
    end else if (tbl_we && tbl_idx != '0) begin
      r_tbl[tbl_idx] <= tbl_hp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hp    <= '0;
      r_phase <= '0;
      r_tempo <= TEMPO_W'(1);
      r_tick  <= '0;
      r_beats <= BEAT_W'(1);
      r_beat  <= '0;
      r_step  <= '0;
      r_spk   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_spk   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (start && len != '0) begin
            r_state <= S_LOAD;
            r_step  <= '0;
            r_busy  <= 1'b1;
          end
          S_LOAD: begin
            r_hp    <= w_hp;
            r_beats <= (w_beats_raw == '0) ? BEAT_W'(1) : w_beats_raw;
            r_tempo <= (tempo == '0) ? TEMPO_W'(1) : tempo;
            r_phase <= '0;
            r_tick  <= '0;
            r_beat  <= '0;
            r_spk   <= 1'b0;
            r_state <= S_PLAY;
          end
          S_PLAY: begin
            if (r_hp != '0) begin
              if (r_phase == r_hp - 1'b1) begin
                r_phase <= '0;
                r_spk   <= ~r_spk;
              end else begin
                r_phase <= r_phase + 1'b1;
              end
            end
            if (w_tick_end) begin
              r_tick <= '0;
              r_beat <= r_beat + 1'b1;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
            // End of step overrides any toggle above: LOAD and DONE are silent.
            if (w_step_end) begin
              r_spk <= 1'b0;
              if (!w_last) begin
                r_step  <= r_step + 1'b1;
                r_state <= S_LOAD;
              end else if (loop_en) begin
                r_step  <= '0;
                r_state <= S_LOAD;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign speaker_out = r_spk;
  assign busy        = r_busy;
  assign step_idx    = r_step;
  assign done        = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: a table of single-step runs plus
// hand-written sequences for multi-step, loop, stop, live update and reset.
module tb_melody_sequencer;
  localparam int ADDR_W = 5, NOTE_W = 4, BEAT_W = 4, HP_W = 24, TEMPO_W = 24;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, stop = 0, loop_en = 0;
  logic [ADDR_W:0] len = '0;
  logic [TEMPO_W-1:0] tempo = '0;
  logic seq_we = 0, tbl_we = 0;
  logic [ADDR_W-1:0] seq_addr = '0;
  logic [NOTE_W-1:0] seq_note = '0, tbl_idx = '0;
  logic [BEAT_W-1:0] seq_beats = '0;
  logic [HP_W-1:0] tbl_hp = '0;
  logic speaker_out, busy, done;
  logic [ADDR_W-1:0] step_idx;

  int n_tests = 0, n_fail = 0;

  melody_sequencer #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .BEAT_W(BEAT_W),
                     .HP_W(HP_W), .TEMPO_W(TEMPO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .len(len), .tempo(tempo), .seq_we(seq_we), .seq_addr(seq_addr),
    .seq_note(seq_note), .seq_beats(seq_beats), .tbl_we(tbl_we),
    .tbl_idx(tbl_idx), .tbl_hp(tbl_hp), .speaker_out(speaker_out),
    .busy(busy), .step_idx(step_idx), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    int note; int hp; int beats; int tmp;
    int exp_busy; int exp_rise; int exp_high; int exp_done;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr_tbl(input int idx, input int hp);
    tbl_we = 1; tbl_idx = NOTE_W'(idx); tbl_hp = HP_W'(hp);
    @(negedge clk); tbl_we = 0;
  endtask

  task automatic wr_seq(input int a, input int n, input int b);
    seq_we = 1; seq_addr = ADDR_W'(a); seq_note = NOTE_W'(n); seq_beats = BEAT_W'(b);
    @(negedge clk); seq_we = 0;
  endtask

  // k=1 is the LOAD cycle after start is sampled; returns after DUT is back in IDLE.
  task automatic run(input int ln, output int busy_n, output int rise_k,
                     output int high_n, output int done_k, output int done_step);
    busy_n = 0; rise_k = 0; high_n = 0; done_k = 0; done_step = -1;
    len = (ADDR_W+1)'(ln); start = 1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
      if (busy) busy_n++;
      if (speaker_out) high_n++;
      if (speaker_out && rise_k == 0) rise_k = k;
      if (done) begin done_k = k; done_step = int'(step_idx); break; end
    end
    start = 0;
    @(negedge clk);
  endtask

  initial begin
    int b, r, h, d, s, dn, prev, rise0, fall0, rise1, hi2, maxb;
    vecs[0] = '{1, 3, 2, 2,  5, 5, 1,  6};
    vecs[1] = '{2, 1, 4, 1,  5, 3, 2,  6};
    vecs[2] = '{0, 0, 3, 0,  4, 0, 0,  5};
    vecs[3] = '{3, 0, 2, 3,  7, 0, 0,  8};
    vecs[4] = '{4, 2, 0, 5,  6, 4, 2,  7};
    vecs[5] = '{15, 4, 15, 1, 16, 6, 7, 17};

    repeat (3) @(negedge clk);
    chk("reset_spk", int'(speaker_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_step", int'(step_idx), 0);
    rst_n = 1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].note != 0) wr_tbl(vecs[i].note, vecs[i].hp);
      wr_seq(0, vecs[i].note, vecs[i].beats);
      tempo = TEMPO_W'(vecs[i].tmp);
      run(1, b, r, h, d, s);
      chk($sformatf("v%0d_busy", i), b, vecs[i].exp_busy);
      chk($sformatf("v%0d_rise", i), r, vecs[i].exp_rise);
      chk($sformatf("v%0d_high", i), h, vecs[i].exp_high);
      chk($sformatf("v%0d_done", i), d, vecs[i].exp_done);
    end

    // Rest step then beats=0 with tempo=0.
    wr_seq(0, 0, 3); wr_seq(1, 2, 0); wr_tbl(2, 1); tempo = '0;
    run(2, b, r, h, d, s);
    chk("rest_busy", b, 6);
    chk("rest_high", h, 0);
    chk("rest_done", d, 7);
    chk("rest_step", s, 1);

    // Loop mode, then drop loop_en during step 1.
    wr_tbl(1, 3); wr_seq(0, 1, 1); wr_seq(1, 2, 1);
    tempo = TEMPO_W'(1); len = (ADDR_W+1)'(2); loop_en = 1; start = 1; dn = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
      if (done) dn++;
      chk($sformatf("loop_step_k%0d", k), int'(step_idx), ((k - 1) / 2) % 2);
    end
    chk("loop_no_done", dn, 0);
    loop_en = 0;
    @(negedge clk);
    chk("loop_end_done", int'(done), 1);
    chk("loop_end_step", int'(step_idx), 1);
    @(negedge clk);
    chk("loop_end_done_clr", int'(done), 0);
    chk("loop_end_busy", int'(busy), 0);

    // Stop during PLAY of step 3, with start raised in the same cycle.
    wr_tbl(1, 1); wr_seq(0, 1, 1); wr_seq(1, 1, 1); wr_seq(2, 1, 1); wr_seq(3, 1, 4);
    tempo = TEMPO_W'(1); len = (ADDR_W+1)'(5); start = 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
    end
    chk("stop_pre_spk", int'(speaker_out), 1);
    chk("stop_pre_step", int'(step_idx), 3);
    stop = 1; start = 1;
    @(negedge clk);
    stop = 0; start = 0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_spk", int'(speaker_out), 0);
    chk("stop_done", int'(done), 0);
    chk("stop_step", int'(step_idx), 3);
    @(negedge clk);
    chk("stop_stays_idle", int'(busy), 0);

    // Table rewritten while step 0 plays; index 0 write must not un-silence rests.
    wr_tbl(1, 3); wr_seq(0, 1, 2); wr_seq(1, 1, 2); wr_seq(2, 0, 1);
    tempo = TEMPO_W'(4); len = (ADDR_W+1)'(3); start = 1;
    prev = 0; rise0 = 0; fall0 = 0; rise1 = 0; hi2 = 0; d = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
      if (k <= 9 && speaker_out && !prev && rise0 == 0) rise0 = k;
      if (k <= 9 && !speaker_out && prev && fall0 == 0) fall0 = k;
      if (k >= 10 && k <= 18 && speaker_out && !prev && rise1 == 0) rise1 = k;
      if (k >= 19 && speaker_out) hi2++;
      if (done && d == 0) d = k;
      prev = int'(speaker_out);
      if (k == 3) begin tbl_we = 1; tbl_idx = NOTE_W'(1); tbl_hp = HP_W'(5); end
      if (k == 4) begin tbl_idx = '0; tbl_hp = HP_W'(7); end
      if (k == 5) tbl_we = 0;
    end
    chk("live_rise0", rise0, 5);
    chk("live_fall0", fall0, 8);
    chk("live_rise1", rise1, 16);
    chk("live_rest_silent", hi2, 0);
    chk("live_done", d, 24);

    // Asynchronous reset mid-PLAY clears outputs and the period table.
    wr_seq(0, 1, 1); wr_seq(1, 1, 4);
    tempo = TEMPO_W'(4); len = (ADDR_W+1)'(2); start = 1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
    end
    chk("arst_pre_spk", int'(speaker_out), 1);
    chk("arst_pre_step", int'(step_idx), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_spk", int'(speaker_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_step", int'(step_idx), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    wr_seq(0, 1, 2); tempo = TEMPO_W'(1);
    run(1, b, r, h, d, s);
    chk("arst_tbl_busy", b, 3);
    chk("arst_tbl_silent", h, 0);
    chk("arst_tbl_done", d, 4);
    len = '0; start = 1; maxb = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) maxb = 1;
    end
    start = 0;
    chk("len0_ignored", maxb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
